uart_rx_mmio: RTL and testbench

//  Memory-mapped UART receiver: the input counterpart of the core's write-only UART console.

---
 rtl/uart_rx_mmio.sv | 331 +++++++++++++++++++++++++++++++++
 tb/tb_uart_rx_mmio.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_mmio.sv
// uart_rx_mmio: memory-mapped UART receiver.
// Deserialises 8N1 frames from rx_serial into a small receive FIFO that load
// instructions in the MEM stage can read back with one cycle of latency.
// Optional feature macro: UART_RX_PARITY_EN. When it is defined, frames are
// 8E1 and a parity mismatch discards the byte and sets a sticky parity_err.
module uart_rx_mmio #(
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [31:0] DATA_ADDR    = 32'hFFFF_0004,
  parameter logic [31:0] STATUS_ADDR  = 32'hFFFF_0008
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_serial,
  input  logic [31:0] addr,
  input  logic        load_en,
  output logic [31:0] read_data,
  output logic        rsp_hit,
  output logic        rx_ready
);

  localparam int CNT_W   = $clog2(CLKS_PER_BIT);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int COUNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [CNT_W-1:0]   HALF_CNT = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [COUNT_W-1:0] FULL_CNT = COUNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchroniser and receive FSM
  // ---------------------------------------------------------------------------
  logic             rx_meta_reg;
  logic             rx_sync_reg;
  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] bit_cnt_reg;
  logic [2:0]       bit_idx_reg;
  logic [7:0]       shift_reg;

  // Control strobes decoded from the FSM state
  logic cnt_clear;
  logic idx_clear;
  logic shift_en;
  logic frame_push;
  logic frame_err_set;
`ifdef UART_RX_PARITY_EN
  logic parity_load;
  logic parity_mismatch;
  logic parity_bad_reg;
  logic parity_err_reg;
`endif
  logic parity_err;

  // Two-flop synchroniser; idles high so reset never looks like a start bit
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
    end else begin
      rx_meta_reg <= rx_serial;
      rx_sync_reg <= rx_meta_reg;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (!rx_sync_reg) begin
          state_next = ST_START;
        end
      end
      ST_START: begin
        // A start bit that is high again at mid-bit was only a glitch
        if (bit_cnt_reg == HALF_CNT) begin
          state_next = rx_sync_reg ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_cnt_reg == LAST_CNT && bit_idx_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
          state_next = ST_PARITY;
`else
          state_next = ST_STOP;
`endif
        end
      end
      ST_PARITY: begin
        if (bit_cnt_reg == LAST_CNT) begin
          state_next = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_cnt_reg == LAST_CNT) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM output decode: counter control, sampling strobes and frame verdict
  always_comb begin
    cnt_clear     = 1'b0;
    idx_clear     = 1'b0;
    shift_en      = 1'b0;
    frame_push    = 1'b0;
    frame_err_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_load     = 1'b0;
    parity_mismatch = (^shift_reg) ^ rx_sync_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        cnt_clear = 1'b1;
      end
      ST_START: begin
        idx_clear = 1'b1;
        if (bit_cnt_reg == HALF_CNT) begin
          cnt_clear = 1'b1;
        end
      end
      ST_DATA: begin
        if (bit_cnt_reg == LAST_CNT) begin
          cnt_clear = 1'b1;
          shift_en  = 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (bit_cnt_reg == LAST_CNT) begin
          cnt_clear   = 1'b1;
          parity_load = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (bit_cnt_reg == LAST_CNT) begin
          cnt_clear = 1'b1;
          if (rx_sync_reg) begin
`ifdef UART_RX_PARITY_EN
            frame_push = !parity_bad_reg;
`else
            frame_push = 1'b1;
`endif
          end else begin
            frame_err_set = 1'b1;
          end
        end
      end
      default: cnt_clear = 1'b1;
    endcase
  end

  // Bit-period counter, bit index and LSB-first shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_reg <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
    end else begin
      bit_cnt_reg <= cnt_clear ? '0 : bit_cnt_reg + CNT_W'(1);
      if (idx_clear) begin
        bit_idx_reg <= '0;
      end else if (shift_en) begin
        bit_idx_reg <= bit_idx_reg + 3'd1;
      end
      if (shift_en) begin
        shift_reg <= {rx_sync_reg, shift_reg[7:1]};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]         fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [COUNT_W-1:0] count_reg;
  logic [COUNT_W-1:0] count_next;
  logic               fifo_empty;
  logic               fifo_full;
  logic               data_req;
  logic               status_req;
  logic               do_pop;
  logic               do_push;
  logic               overrun_set;

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == FULL_CNT);
  assign data_req   = load_en && (addr == DATA_ADDR);
  assign status_req = load_en && (addr == STATUS_ADDR);
  // A pop frees the slot in the same cycle, so push on full is legal then
  assign do_pop      = data_req && !fifo_empty;
  assign do_push     = frame_push && (!fifo_full || do_pop);
  assign overrun_set = frame_push && fifo_full && !do_pop;
  assign rx_ready    = !fifo_empty;

  // Next occupancy: simultaneous push and pop leave it unchanged
  always_comb begin
    count_next = count_reg;
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + COUNT_W'(1);
      2'b01:   count_next = count_reg - COUNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  // FIFO storage write port (no reset so it maps onto RAM)
  always_ff @(posedge clk) begin
    if (do_push) begin
      fifo_mem[wr_ptr_reg] <= shift_reg;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally (power-of-2 depth)
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      count_reg <= count_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky error flags and MMIO read response
  // ---------------------------------------------------------------------------
  logic        overrun_reg;
  logic        frame_err_reg;
  logic [31:0] status_word;

`ifdef UART_RX_PARITY_EN
  // Parity verdict for the current frame plus its sticky error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_bad_reg <= 1'b0;
      parity_err_reg <= 1'b0;
    end else begin
      if (state_reg == ST_START) begin
        parity_bad_reg <= 1'b0;
      end else if (parity_load) begin
        parity_bad_reg <= parity_mismatch;
      end
      if (parity_load && parity_mismatch) begin
        parity_err_reg <= 1'b1;
      end else if (status_req) begin
        parity_err_reg <= 1'b0;
      end
    end
  end
  assign parity_err = parity_err_reg;
`else
  assign parity_err = 1'b0;
`endif

  // Sticky overrun/framing flags: a new event beats a same-cycle status clear
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      if (overrun_set) begin
        overrun_reg <= 1'b1;
      end else if (status_req) begin
        overrun_reg <= 1'b0;
      end
      if (frame_err_set) begin
        frame_err_reg <= 1'b1;
      end else if (status_req) begin
        frame_err_reg <= 1'b0;
      end
    end
  end

  // Status register image as seen before this cycle's updates
  always_comb begin
    status_word       = 32'h0;
    status_word[0]    = !fifo_empty;
    status_word[1]    = fifo_full;
    status_word[2]    = overrun_reg;
    status_word[3]    = frame_err_reg;
    status_word[4]    = parity_err;
    status_word[15:8] = 8'(count_reg);
  end

  // Registered read response, aligned with the data-memory read latency
  always_ff @(posedge clk) begin
    if (rst) begin
      read_data <= 32'h0;
      rsp_hit   <= 1'b0;
    end else begin
      rsp_hit <= data_req || status_req;
      if (data_req) begin
        read_data <= fifo_empty ? 32'h0 : {23'b0, 1'b1, fifo_mem[rd_ptr_reg]};
      end else if (status_req) begin
        read_data <= status_word;
      end else begin
        read_data <= 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Testbench for uart_rx_mmio (CLKS_PER_BIT=16, FIFO_DEPTH=4).
// Table-driven MMIO read vectors plus hand-written serial frame sequences.
module tb_uart_rx_mmio;

  localparam int          CPB   = 16;
  localparam int          DEPTH = 4;
  localparam logic [31:0] DADDR = 32'hFFFF_0004;
  localparam logic [31:0] SADDR = 32'hFFFF_0008;
  localparam logic [31:0] OADDR = 32'hFFFF_000C;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_serial = 1'b1;
  logic [31:0] addr = 32'h0;
  logic        load_en = 1'b0;
  logic [31:0] read_data;
  logic        rsp_hit;
  logic        rx_ready;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] exp_data;
    logic        exp_hit;
  } vec_t;

  vec_t vecs [10];

  uart_rx_mmio #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH),
    .DATA_ADDR   (DADDR),
    .STATUS_ADDR (SADDR)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_serial(rx_serial),
    .addr     (addr),
    .load_en  (load_en),
    .read_data(read_data),
    .rsp_hit  (rsp_hit),
    .rx_ready (rx_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Hold one serial bit on the line for a full bit period
  task automatic drive_bit(input logic v);
    @(negedge clk);
    rx_serial = v;
    repeat (CPB - 1) @(negedge clk);
  endtask

  // Send one frame; par_flip inverts the even-parity bit when parity is built in
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^b) ^ par_flip);
`else
    if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
    drive_bit(stop_bit);
    @(negedge clk);
    rx_serial = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  // One-cycle load request; response sampled at the following negedge
  task automatic mmio_read(input logic [31:0] a, output logic [31:0] d, output logic h);
    @(negedge clk);
    addr    = a;
    load_en = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
    addr    = 32'h0;
    d = read_data;
    h = rsp_hit;
  endtask

  task automatic read_check(input string name, input logic [31:0] a,
                            input logic [31:0] exp_d, input logic exp_h);
    logic [31:0] d;
    logic        h;
    mmio_read(a, d, h);
    check({name, ".data"}, d, exp_d);
    check({name, ".hit"}, {31'b0, h}, {31'b0, exp_h});
  endtask

  initial begin
    logic [31:0] d;
    logic        h;

    // Read vectors applied after five bytes were sent into a 4-deep FIFO
    vecs[0] = '{"ovr_status1", SADDR, 32'h0000_0407, 1'b1};
    vecs[1] = '{"ovr_status2", SADDR, 32'h0000_0403, 1'b1};
    vecs[2] = '{"other_addr",  OADDR, 32'h0000_0000, 1'b0};
    vecs[3] = '{"pop_01",      DADDR, 32'h0000_0101, 1'b1};
    vecs[4] = '{"pop_02",      DADDR, 32'h0000_0102, 1'b1};
    vecs[5] = '{"mid_status",  SADDR, 32'h0000_0201, 1'b1};
    vecs[6] = '{"pop_03",      DADDR, 32'h0000_0103, 1'b1};
    vecs[7] = '{"pop_04",      DADDR, 32'h0000_0104, 1'b1};
    vecs[8] = '{"end_status",  SADDR, 32'h0000_0000, 1'b1};
    vecs[9] = '{"pop_empty",   DADDR, 32'h0000_0000, 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset.read_data", read_data, 32'h0);
    check("reset.rsp_hit", {31'b0, rsp_hit}, 32'h0);
    check("reset.rx_ready", {31'b0, rx_ready}, 32'h0);

    // Single byte 0xA5
    send_frame(8'hA5, 1'b1, 1'b0);
    check("a5.rx_ready", {31'b0, rx_ready}, 32'h1);
    read_check("a5.data", DADDR, 32'h0000_01A5, 1'b1);
    read_check("a5.status", SADDR, 32'h0000_0000, 1'b1);

    // Empty read
    read_check("empty.data", DADDR, 32'h0, 1'b1);
    read_check("empty.status", SADDR, 32'h0, 1'b1);

    // Overrun: five bytes into four entries, then the read table
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) read_check(vecs[i].name, vecs[i].a, vecs[i].exp_data, vecs[i].exp_hit);

    // Short low glitch on the idle line
    @(negedge clk);
    rx_serial = 1'b0;
    repeat (6) @(negedge clk);
    rx_serial = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch.rx_ready", {31'b0, rx_ready}, 32'h0);
    read_check("glitch.status", SADDR, 32'h0, 1'b1);

    // Framing error, sticky clear, then good frame
    send_frame(8'h3C, 1'b0, 1'b0);
    read_check("ferr.status1", SADDR, 32'h0000_0008, 1'b1);
    read_check("ferr.status2", SADDR, 32'h0000_0000, 1'b1);
    send_frame(8'h3C, 1'b1, 1'b0);
    read_check("ferr.good", DADDR, 32'h0000_013C, 1'b1);

    // Back-to-back DATA reads pop one entry per cycle
    send_frame(8'h5A, 1'b1, 1'b0);
    send_frame(8'h6B, 1'b1, 1'b0);
    @(negedge clk);
    addr    = DADDR;
    load_en = 1'b1;
    @(negedge clk);
    check("b2b.first", read_data, 32'h0000_015A);
    @(negedge clk);
    load_en = 1'b0;
    addr    = 32'h0;
    check("b2b.second", read_data, 32'h0000_016B);
    read_check("b2b.status", SADDR, 32'h0, 1'b1);

    // Reset in the middle of frame 0x77 with one byte already buffered
    send_frame(8'h11, 1'b1, 1'b0);
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    @(negedge clk);
    rx_serial = 1'b0;
    repeat (5) @(negedge clk);
    addr    = SADDR;
    load_en = 1'b1;
    @(negedge clk);
    load_en   = 1'b0;
    addr      = 32'h0;
    rst       = 1'b1;
    rx_serial = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst.read_data", read_data, 32'h0);
    check("midrst.rsp_hit", {31'b0, rsp_hit}, 32'h0);
    check("midrst.rx_ready", {31'b0, rx_ready}, 32'h0);
    repeat (200) @(negedge clk);
    read_check("midrst.status", SADDR, 32'h0, 1'b1);
    send_frame(8'h55, 1'b1, 1'b0);
    read_check("midrst.next", DADDR, 32'h0000_0155, 1'b1);

`ifdef UART_RX_PARITY_EN
    // Bad parity discards the byte; good parity accepts it
    send_frame(8'h03, 1'b1, 1'b1);
    read_check("par.bad_status", SADDR, 32'h0000_0010, 1'b1);
    send_frame(8'h03, 1'b1, 1'b0);
    read_check("par.good", DADDR, 32'h0000_0103, 1'b1);
`endif

    mmio_read(OADDR, d, h);
    check("final.other_hit", {31'b0, h}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
